// File: rtl/operand_display_scan_pkg.sv
// Shared encodings for the operand display scanner: FSM states,
// digit-select codes and the 7-segment hex glyph table.
package operand_display_scan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SHOW_A,
        ST_GAP_A,
        ST_SHOW_B,
        ST_GAP_B,
        ST_SHOW_RH,
        ST_GAP_RH,
        ST_SHOW_RL,
        ST_GAP_RL
    } state_t;

    localparam logic [2:0] DSEL_NONE = 3'd0;
    localparam logic [2:0] DSEL_A    = 3'd1;
    localparam logic [2:0] DSEL_B    = 3'd2;
    localparam logic [2:0] DSEL_RH   = 3'd3;
    localparam logic [2:0] DSEL_RL   = 3'd4;

    // Segments {g,f,e,d,c,b,a}; element n is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/operand_display_scan_hex.sv
// Nibble to active-high 7-segment glyph decoder.
module hex_to_7seg
    import operand_display_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPHS[nib_i];

endmodule

// File: rtl/operand_display_scan.sv
// Scans snapshotted A, B and result nibbles onto one 7-segment digit
// with a programmable dwell and blank gap per digit.
module operand_display_scan
    import operand_display_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [7:0] result,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_sel,
    output logic       frame_done
);

    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2((CMAX > 2) ? CMAX : 2);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_GAP = BLANK_CYCLES > 0;

    state_t        state_q, state_d, succ;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    a_s_q, a_s_d;
    logic [3:0]    b_s_q, b_s_d;
    logic [7:0]    r_s_q, r_s_d;
    logic          last, wrap, snap;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          show;

    always_comb begin
        succ = ST_IDLE;
        last = 1'b0;
        wrap = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                succ = ST_SHOW_A;
                last = 1'b1;
            end
            ST_SHOW_A: begin
                succ = HAS_GAP ? ST_GAP_A : ST_SHOW_B;
                last = (cnt_q == DW_LAST);
            end
            ST_GAP_A: begin
                succ = ST_SHOW_B;
                last = (cnt_q == BL_LAST);
            end
            ST_SHOW_B: begin
                succ = HAS_GAP ? ST_GAP_B : ST_SHOW_RH;
                last = (cnt_q == DW_LAST);
            end
            ST_GAP_B: begin
                succ = ST_SHOW_RH;
                last = (cnt_q == BL_LAST);
            end
            ST_SHOW_RH: begin
                succ = HAS_GAP ? ST_GAP_RH : ST_SHOW_RL;
                last = (cnt_q == DW_LAST);
            end
            ST_GAP_RH: begin
                succ = ST_SHOW_RL;
                last = (cnt_q == BL_LAST);
            end
            ST_SHOW_RL: begin
                succ = HAS_GAP ? ST_GAP_RL : ST_SHOW_A;
                last = (cnt_q == DW_LAST);
                wrap = !HAS_GAP;
            end
            ST_GAP_RL: begin
                succ = ST_SHOW_A;
                last = (cnt_q == BL_LAST);
                wrap = 1'b1;
            end
            default: begin
                succ = ST_IDLE;
                last = 1'b1;
            end
        endcase
    end

    // Snapshots are taken only when a frame starts, never mid-frame.
    assign snap       = enable && last && (wrap || state_q == ST_IDLE);
    assign frame_done = enable && last && wrap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_s_d   = a_s_q;
        b_s_d   = b_s_q;
        r_s_d   = r_s_q;
        if (enable) begin
            if (last) begin
                state_d = succ;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (snap) begin
            a_s_d = a;
            b_s_d = b;
            r_s_d = result;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_s_q   <= '0;
            b_s_q   <= '0;
            r_s_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_s_q   <= a_s_d;
            b_s_q   <= b_s_d;
            r_s_q   <= r_s_d;
        end
    end

    always_comb begin
        nib       = a_s_q;
        show      = 1'b0;
        dp        = 1'b0;
        digit_sel = DSEL_NONE;
        unique case (state_q)
            ST_SHOW_A: begin
                nib       = a_s_q;
                show      = 1'b1;
                digit_sel = DSEL_A;
            end
            ST_SHOW_B: begin
                nib       = b_s_q;
                show      = 1'b1;
                digit_sel = DSEL_B;
            end
            ST_SHOW_RH: begin
                nib       = r_s_q[7:4];
                show      = 1'b1;
                dp        = 1'b1;
                digit_sel = DSEL_RH;
            end
            ST_SHOW_RL: begin
                nib       = r_s_q[3:0];
                show      = 1'b1;
                dp        = 1'b1;
                digit_sel = DSEL_RL;
            end
            default: ;
        endcase
    end

    hex_to_7seg u_hex (
        .nib_i (nib),
        .seg_o (glyph)
    );

    assign seg = show ? glyph : 7'h00;

endmodule

// File: doc/operand_display_scan.md
Name: operand_display_scan

Overview:
- Read-side companion to the operand latch. Takes the latched 4-bit operands A and B and the 8-bit ALU result, and shows them in turn on the single 7-segment output.
- Cycles through A, B, result-high nibble and result-low nibble, with a programmable dwell time per digit and a blank gap between digits.
- Snapshots all inputs once per frame, so a frame never mixes old and new operands.

Parameters:
- DWELL_CYCLES, 4, enabled clock cycles each digit is shown; must be >= 1 (silicon build uses ~10_000_000).
- BLANK_CYCLES, 2, enabled clock cycles of blank gap after each digit; 0 removes the gaps.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous reset, active-high (despite the name); asserted when 1.
- enable  input  1  scan advance enable; 0 freezes the scan.
- a  input  4  latched operand A.
- b  input  4  latched operand B.
- result  input  8  ALU result.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  output  1  decimal point, 1 while a result nibble is shown.
- digit_sel  output  3  item shown: 0 none, 1 A, 2 B, 3 result[7:4], 4 result[3:0].
- frame_done  output  1  one-cycle pulse at end of each full frame.

Behaviour:
- Reset (async, reset_n=1):
  - state=IDLE, counter=0, snapshot regs (a_s, b_s, r_s)=0.
  - Outputs: seg=0, dp=0, digit_sel=0, frame_done=0.
- States: IDLE, SHOW_A, GAP_A, SHOW_B, GAP_B, SHOW_RH, GAP_RH, SHOW_RL, GAP_RL.
- Outputs are combinational functions of the state and snapshot registers only; there is no combinational path from a, b or result to the outputs.
  - SHOW_A: seg=hex(a_s), digit_sel=1.
  - SHOW_B: seg=hex(b_s), digit_sel=2.
  - SHOW_RH: seg=hex(r_s[7:4]), digit_sel=3.
  - SHOW_RL: seg=hex(r_s[3:0]), digit_sel=4.
  - dp=1 only in SHOW_RH and SHOW_RL.
  - IDLE and all GAP_* states: seg=0, dp=0, digit_sel=0.
- Hex glyphs 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- IDLE with enable=1: capture a, b, result into a_s, b_s, r_s; next state SHOW_A with counter=0.
- Each SHOW_* state lasts exactly DWELL_CYCLES enabled cycles and each GAP_* state exactly BLANK_CYCLES. The counter runs 0..N-1 and clears on every state change.
- BLANK_CYCLES=0: each SHOW_* goes directly to the next SHOW_*; GAP states are never entered.
- Frame wrap:
  - On the last enabled cycle of GAP_RL (or of SHOW_RL when BLANK_CYCLES=0), frame_done=1 for that cycle.
  - On the same edge, new snapshots are captured and the state goes to SHOW_A.
  - The frame never returns to IDLE.
- Frame length = 4*(DWELL_CYCLES+BLANK_CYCLES) enabled cycles; 24 with the defaults.
- enable=0 in any state: state, counter and snapshots hold, outputs unchanged, frame_done=0. Scan resumes exactly where it stopped.
- Input changes mid-frame have no effect until the next snapshot edge.
- Reset mid-frame: immediate return to IDLE with blank outputs; the next enable restarts at SHOW_A.
- Counter width = clog2(max(DWELL_CYCLES, BLANK_CYCLES, 2)).

Decomposition:
- Shared package holds:
  - the state encoding constants;
  - the digit_sel codes (DSEL_NONE=0, DSEL_A=1, DSEL_B=2, DSEL_RH=3, DSEL_RL=4);
  - the 16-entry hex glyph constants.
- One combinational sub-module, hex_to_7seg (4-bit in, 7-bit out), instantiated once and driven by a nibble mux selected by the state.

Test Plan:
- Reset then enable=1 with a=3, b=A, result=8'h5C.
  - Expect: cycle 1 after enable, seg=4F with digit_sel=1 for 4 cycles; then seg=0 for 2; then 77/2 for 4; 00 gap; 6D with dp=1 and digit_sel=3; gap; 39 with dp=1 and digit_sel=4; frame_done on cycle 24.
- Snapshot isolation: change a 3→7 during SHOW_B.
  - Expect: the current frame shows no change; the next SHOW_A shows 07.
- Enable gating: drop enable for 5 cycles mid-SHOW_RH.
  - Expect: seg=6D held for all 5 cycles; the remaining dwell completes after enable returns; the frame ends 5 cycles later than nominal.
- Reset mid-frame: assert reset_n during SHOW_B, asynchronously between edges.
  - Expect: outputs go to 0 immediately without waiting for a clock edge; after release with enable=1, restart at SHOW_A.
- Parameter override DWELL_CYCLES=1, BLANK_CYCLES=0, inputs a=F, b=0, result=8'h12.
  - Expect: digit_sel sequence 1,2,3,4,1,… with seg 71, 3F, 06, 5B; frame_done every 4th cycle.
- Glyph sweep: a = 0..F across 16 frames.
  - Expect: the seg value in SHOW_A matches the glyph table for every value.
